// File: rtl/aibnd_dll_lockctl_if.sv
// Phase-detector samples, loop controls and delay-code outputs of the DLL lock controller.
// Master drives the loop controls and detector samples; slave drives the code and status.
interface aibnd_dll_lockctl_if #(
   parameter int CODE_W = 8
);
   logic              dll_en;
   logic [CODE_W-1:0] code_init;
   logic              ovrd_en;
   logic [CODE_W-1:0] ovrd_code;
   logic              t_up;
   logic              t_down;
   logic [CODE_W-1:0] dll_code;
   logic              dll_lock;
   logic              sat_hi;
   logic              sat_lo;

   modport master (
      output dll_en, code_init, ovrd_en, ovrd_code, t_up, t_down,
      input  dll_code, dll_lock, sat_hi, sat_lo
   );

   modport slave (
      input  dll_en, code_init, ovrd_en, ovrd_code, t_up, t_down,
      output dll_code, dll_lock, sat_hi, sat_lo
   );
endinterface

// File: rtl/aibnd_dll_lockctl.sv
// DLL loop controller: syncs and filters PD votes, steps the delay code by one LSB, settles, detects lock.
// Latency: pad to vote 2 cycles, threshold vote to code 1 cycle; no backpressure, votes dropped while settling.
module aibnd_dll_lockctl #(
   parameter int CODE_W     = 8,
   parameter int FILT_TH    = 4,
   parameter int SETTLE_CYC = 8,
   parameter int LOCK_FLIPS = 4
) (
   input logic                clk,
   input logic                dll_reset_n,
   aibnd_dll_lockctl_if.slave bus
);
   localparam int ACC_W = $clog2(FILT_TH) + 2;
   localparam logic signed [ACC_W-1:0] TH_P = ACC_W'(FILT_TH);
   localparam logic signed [ACC_W-1:0] TH_N = ACC_W'(-FILT_TH);
   localparam logic [CODE_W-1:0] CODE_MAX = '1;

   typedef enum logic [1:0] {IDLE, ACQ, SETTLE, LOCKED} state_t;

   state_t                   state_q, state_nxt;
   logic [1:0]               up_sync, dn_sync;
   logic                     up_s, dn_s;
   logic signed [ACC_W-1:0]  vote, acc_q, acc_nxt;
   logic [CODE_W-1:0]        code_q;
   logic [7:0]               settle_q;
   logic [3:0]               flips_q;
   logic                     lock_q, sat_hi_q, sat_lo_q, prev_up_q, prev_vld_q;
   logic                     tracking, step_req, step_up, step_blk;

   always_ff @(posedge clk) begin
      if (!dll_reset_n) begin
         up_sync <= '0;
         dn_sync <= '0;
      end else begin
         up_sync <= {up_sync[0], bus.t_up};
         dn_sync <= {dn_sync[0], bus.t_down};
      end
   end

   assign up_s = up_sync[1];
   assign dn_s = dn_sync[1];

   always_comb begin
      vote = '0;
      if (up_s && !dn_s)
         vote = ACC_W'(1);
      else if (!up_s && dn_s)
         vote = '1;
   end

   assign tracking = (state_q == ACQ) || (state_q == LOCKED);
   assign acc_nxt  = acc_q + vote;
   assign step_up  = (acc_nxt == TH_P);
   assign step_req = tracking && (step_up || (acc_nxt == TH_N));
   assign step_blk = step_up ? (code_q == CODE_MAX) : (code_q == '0);

   always_ff @(posedge clk) begin
      if (!dll_reset_n)
         state_q <= IDLE;
      else
         state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         IDLE:        state_nxt = ACQ;
         ACQ, LOCKED: if (step_req) state_nxt = SETTLE;
         SETTLE:      if (settle_q == '0) state_nxt = lock_q ? LOCKED : ACQ;
         default:     state_nxt = IDLE;
      endcase
      if (!bus.dll_en)
         state_nxt = IDLE;
   end

   // Disable and IDLE share the clear path so an aborted settle leaves nothing behind.
   always_ff @(posedge clk) begin
      if (!dll_reset_n || !bus.dll_en || state_q == IDLE) begin
         code_q     <= bus.code_init;
         acc_q      <= '0;
         settle_q   <= '0;
         flips_q    <= '0;
         lock_q     <= 1'b0;
         sat_hi_q   <= 1'b0;
         sat_lo_q   <= 1'b0;
         prev_up_q  <= 1'b0;
         prev_vld_q <= 1'b0;
      end else if (state_q == SETTLE) begin
         acc_q <= '0;
         if (settle_q != '0)
            settle_q <= settle_q - 8'd1;
      end else if (step_req) begin
         acc_q    <= '0;
         settle_q <= 8'(SETTLE_CYC - 1);
         if (step_blk) begin
            if (step_up)
               sat_hi_q <= 1'b1;
            else
               sat_lo_q <= 1'b1;
         end else begin
            code_q     <= step_up ? code_q + 1'b1 : code_q - 1'b1;
            prev_up_q  <= step_up;
            prev_vld_q <= 1'b1;
            if (step_up)
               sat_lo_q <= 1'b0;
            else
               sat_hi_q <= 1'b0;
            // Reversal counting freezes once locked; lock stays until IDLE.
            if (!lock_q) begin
               if (prev_vld_q && (prev_up_q != step_up)) begin
                  flips_q <= flips_q + 4'd1;
                  if (flips_q + 4'd1 == 4'(LOCK_FLIPS))
                     lock_q <= 1'b1;
               end else begin
                  flips_q <= '0;
               end
            end
         end
      end else begin
         acc_q <= acc_nxt;
      end
   end

   assign bus.dll_code = bus.ovrd_en ? bus.ovrd_code : code_q;
   assign bus.dll_lock = lock_q && !bus.ovrd_en;
   assign bus.sat_hi   = sat_hi_q;
   assign bus.sat_lo   = sat_lo_q;
endmodule

// File: tb/tb_aibnd_dll_lockctl.sv
// Scoreboarded bench for aibnd_dll_lockctl: an arithmetic reference model predicts every cycle's outputs.
// Directed scenarios exercise spacing, lock, override, saturation and abort, followed by randomized traffic.
module tb_aibnd_dll_lockctl;
   localparam int CODE_W     = 8;
   localparam int FILT_TH    = 4;
   localparam int SETTLE_CYC = 8;
   localparam int LOCK_FLIPS = 4;
   localparam int CMAX       = (1 << CODE_W) - 1;

   logic clk = 1'b0;
   logic dll_reset_n;
   always #5 clk = ~clk;

   aibnd_dll_lockctl_if #(.CODE_W(CODE_W)) bus ();

   aibnd_dll_lockctl #(
      .CODE_W(CODE_W), .FILT_TH(FILT_TH), .SETTLE_CYC(SETTLE_CYC), .LOCK_FLIPS(LOCK_FLIPS)
   ) dut (
      .clk(clk),
      .dll_reset_n(dll_reset_n),
      .bus(bus)
   );

   typedef struct {
      logic [CODE_W-1:0] code;
      logic              lock;
      logic              shi;
      logic              slo;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   cyc_no = 0;

   // stimulus state
   logic              r_n, en, ov, tu, td;
   logic [CODE_W-1:0] init, ovc;

   // reference model state
   int m_idle = 1, m_settle_left = 0, m_acc = 0, m_code = 0, m_lock = 0;
   int m_shi = 0, m_slo = 0, m_last = 0, m_flips = 0, m_settling = 0;
   int hu0 = 0, hu1 = 0, hd0 = 0, hd1 = 0;

   task automatic cmp(input string name, input logic [CODE_W-1:0] act, input logic [CODE_W-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got 0x%h, expected 0x%h", name, cyc_no, act, exp);
      end
   endtask

   task automatic model_step();
      int up_s, dn_s, v, dir;
      up_s = hu1;
      dn_s = hd1;
      if (!r_n) begin
         hu0 = 0; hu1 = 0; hd0 = 0; hd1 = 0;
      end else begin
         hu1 = hu0; hu0 = int'(tu);
         hd1 = hd0; hd0 = int'(td);
      end
      if (!r_n || !en || m_idle != 0) begin
         m_idle     = (r_n && en && m_idle != 0) ? 0 : 1;
         m_settling = 0;
         m_code = int'(init); m_acc = 0; m_lock = 0; m_shi = 0; m_slo = 0;
         m_last = 0; m_flips = 0;
      end else if (m_settling != 0) begin
         m_settle_left--;
         if (m_settle_left == 0) m_settling = 0;
      end else begin
         v = (up_s == 1 && dn_s == 0) ? 1 : (up_s == 0 && dn_s == 1) ? -1 : 0;
         m_acc += v;
         if (m_acc == FILT_TH || m_acc == -FILT_TH) begin
            dir = (m_acc > 0) ? 1 : -1;
            m_acc = 0;
            m_settling = 1;
            m_settle_left = SETTLE_CYC;
            if (dir > 0 && m_code == CMAX) m_shi = 1;
            else if (dir < 0 && m_code == 0) m_slo = 1;
            else begin
               m_code += dir;
               if (dir > 0) m_slo = 0; else m_shi = 0;
               if (m_lock == 0) begin
                  m_flips = (m_last == -dir) ? m_flips + 1 : 0;
                  if (m_flips == LOCK_FLIPS) m_lock = 1;
               end
               m_last = dir;
            end
         end
      end
   endtask

   // Applies this cycle's inputs, predicts the post-edge outputs, then advances past the edge.
   task automatic cyc(input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         dll_reset_n   = r_n;
         bus.dll_en    = en;
         bus.code_init = init;
         bus.ovrd_en   = ov;
         bus.ovrd_code = ovc;
         bus.t_up      = tu;
         bus.t_down    = td;
         model_step();
         e.code = ov ? ovc : CODE_W'(m_code);
         e.lock = (m_lock != 0) && !ov;
         e.shi  = (m_shi != 0);
         e.slo  = (m_slo != 0);
         exp_q.push_back(e);
         @(posedge clk);
         #2;
      end
   endtask

   task automatic wait_change(input string name, input int limit, output int n);
      logic [CODE_W-1:0] start;
      start = bus.dll_code;
      n = 0;
      do begin
         cyc(1);
         n++;
      end while (bus.dll_code == start && n < limit);
      cmp({name, "_stepped"}, CODE_W'(bus.dll_code != start), 1);
   endtask

   // Monitor: pops one prediction per edge and compares every output.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         cyc_no++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp("sb_code",   bus.dll_code, e.code);
            cmp("sb_lock",   CODE_W'(bus.dll_lock), CODE_W'(e.lock));
            cmp("sb_sat_hi", CODE_W'(bus.sat_hi),   CODE_W'(e.shi));
            cmp("sb_sat_lo", CODE_W'(bus.sat_lo),   CODE_W'(e.slo));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, len, pu, pd;
      r_n = 0; en = 0; ov = 0; tu = 0; td = 0; init = 8'h40; ovc = '0;
      cyc(3);
      cmp("reset_code", bus.dll_code, 8'h40);
      cmp("reset_lock", CODE_W'(bus.dll_lock), 0);

      // constant up: steady step spacing, never locks
      r_n = 1; en = 1; tu = 1; td = 0;
      wait_change("up1", 40, n);
      cmp("first_step_code", bus.dll_code, 8'h41);
      wait_change("up2", 40, n);
      cmp("step_spacing_a", CODE_W'(n), CODE_W'(SETTLE_CYC + FILT_TH));
      wait_change("up3", 40, n);
      cmp("step_spacing_b", CODE_W'(n), CODE_W'(SETTLE_CYC + FILT_TH));
      cmp("up_no_lock", CODE_W'(bus.dll_lock), 0);

      // alternating directions from 0x40: lock on the 4th reversal
      en = 0; cyc(1);
      en = 1;
      for (int i = 0; i < 5; i++) begin
         tu = (i % 2 == 0); td = !tu;
         wait_change("alt", 60, n);
         if (i == 3) cmp("lock_before_4th_rev", CODE_W'(bus.dll_lock), 0);
      end
      cmp("lock_after_4th_rev", CODE_W'(bus.dll_lock), 1);
      cmp("alt_code", bus.dll_code, 8'h41);

      // override while locked
      tu = 1; td = 1; ov = 1; ovc = 8'h12;
      cyc(1);
      cmp("ovrd_code", bus.dll_code, 8'h12);
      cmp("ovrd_lock", CODE_W'(bus.dll_lock), 0);
      cyc(3);
      ov = 0;
      cyc(1);
      cmp("ovrd_rel_code", bus.dll_code, 8'h41);
      cmp("ovrd_rel_lock", CODE_W'(bus.dll_lock), 1);

      // reset while locked
      r_n = 0; cyc(1);
      cmp("rst_lock_code", bus.dll_code, 8'h40);
      cmp("rst_lock_lock", CODE_W'(bus.dll_lock), 0);
      r_n = 1;

      // neutral votes never move the code; then 3 ups must not step, a 4th does
      for (int i = 0; i < 200; i++) begin
         tu = $urandom_range(0, 1); td = tu; cyc(1);
      end
      cmp("neutral_code", bus.dll_code, 8'h40);
      tu = 1; td = 0; cyc(3);
      tu = 1; td = 1; cyc(20);
      cmp("three_votes_no_step", bus.dll_code, 8'h40);
      tu = 1; td = 0; cyc(1);
      tu = 1; td = 1; cyc(3);
      cmp("fourth_vote_step", bus.dll_code, 8'h41);

      // saturation high and low
      en = 0; init = 8'hFF; cyc(1);
      en = 1; tu = 1; td = 0; cyc(40);
      cmp("sat_hi_code", bus.dll_code, 8'hFF);
      cmp("sat_hi_flag", CODE_W'(bus.sat_hi), 1);
      tu = 0; td = 1;
      wait_change("sat_hi_rel", 60, n);
      cmp("sat_hi_rel_code", bus.dll_code, 8'hFE);
      cmp("sat_hi_rel_flag", CODE_W'(bus.sat_hi), 0);
      en = 0; init = 8'h00; cyc(1);
      en = 1; cyc(40);
      cmp("sat_lo_code", bus.dll_code, 8'h00);
      cmp("sat_lo_flag", CODE_W'(bus.sat_lo), 1);
      tu = 1; td = 0;
      wait_change("sat_lo_rel", 60, n);
      cmp("sat_lo_rel_code", bus.dll_code, 8'h01);
      cmp("sat_lo_rel_flag", CODE_W'(bus.sat_lo), 0);

      // disable mid-settle
      en = 0; init = 8'h40; cyc(1);
      en = 1;
      wait_change("pre_abort", 40, n);
      cyc(3);
      en = 0; cyc(1);
      cmp("abort_code", bus.dll_code, 8'h40);
      cmp("abort_flags", CODE_W'({bus.dll_lock, bus.sat_hi, bus.sat_lo}), 0);

      // randomized traffic
      for (int s = 0; s < 70; s++) begin
         len  = $urandom_range(10, 80);
         pu   = $urandom_range(0, 100);
         pd   = $urandom_range(0, 100);
         ov   = ($urandom_range(0, 5) == 0);
         ovc  = CODE_W'($urandom);
         init = ($urandom_range(0, 3) == 0) ? CODE_W'($urandom_range(0, 1) * CMAX) : CODE_W'($urandom);
         for (int c = 0; c < len; c++) begin
            tu  = ($urandom_range(0, 99) < pu);
            td  = ($urandom_range(0, 99) < pd);
            en  = ($urandom_range(0, 199) != 0);
            r_n = ($urandom_range(0, 499) != 0);
            cyc(1);
         end
      end
      r_n = 1; en = 1; ov = 0; cyc(2);

      cmp("scoreboard_drained", CODE_W'(exp_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
